// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Shares the single register-file write port among NUM_REQ requesters with
// round-robin arbitration. A requester holding req_lock keeps priority for up
// to LOCK_MAX consecutive grants (a burst). Each grant is registered onto the
// write port one cycle after the request is sampled. A grant that targets
// register 0 is acknowledged but not issued, because register 0 is
// hard-wired to zero.
//
// Ports:
//   clock            system clock, rising edge
//   reset            asynchronous active-low reset
//   req              per-requester write request (level)
//   req_lock         per-requester burst request (keep priority)
//   req_addr         packed register indices, slice [i*ADDR_W +: ADDR_W]
//   req_data         packed write data,       slice [i*DATA_W +: DATA_W]
//   ack              one-hot one-cycle pulse: request i consumed
//   ctrl_writeEnable registered regfile write enable
//   ctrl_writeReg    registered regfile write index
//   data_writeReg    registered regfile write data
//   zero_drop        one-cycle pulse: granted write to register 0 discarded
//   lock_active      a burst is in progress
//
// NUM_REQ must be a power of two (2..8) so the round-robin index wraps by
// simple truncation. LOCK_MAX must be at least 1; LOCK_MAX=1 disables bursts.

module regfile_write_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        ctrl_writeEnable,
  output logic [ADDR_W-1:0]           ctrl_writeReg,
  output logic [DATA_W-1:0]           data_writeReg,
  output logic                        zero_drop,
  output logic                        lock_active
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);

  // Arbitration state: round-robin pointer and burst bookkeeping.
  logic [IDX_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             lock_q;

  // Unpacked views of the per-requester address and data buses.
  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  // ---- Stage p0: combinational arbitration on the sampled requests ----
  logic                vld_p0;
  logic [IDX_W-1:0]    win_p0;
  logic [IDX_W-1:0]    scan_idx;
  logic [NUM_REQ-1:0]  grant_p0;
  logic [ADDR_W-1:0]   addr_p0;
  logic [DATA_W-1:0]   data_p0;
  logic                zero_p0;
  logic [CNT_W-1:0]    run_cnt;
  logic [IDX_W-1:0]    ptr_nxt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                lock_nxt;

  always_comb begin
    vld_p0   = 1'b0;
    win_p0   = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ptr_q + IDX_W'(k);
      if (!vld_p0 && req[scan_idx]) begin
        vld_p0 = 1'b1;
        win_p0 = scan_idx;
      end
    end
  end

  always_comb begin
    grant_p0 = '0;
    if (vld_p0) begin
      grant_p0 = NUM_REQ'(1) << win_p0;
    end
    addr_p0 = addr_arr[win_p0];
    data_p0 = data_arr[win_p0];
    zero_p0 = (addr_p0 == '0);
  end

  // The burst count only carries over when the same requester that holds the
  // lock wins again; if the lock holder dropped req, someone else wins and
  // starts from zero, so the stale lock is released by that grant.
  always_comb begin
    run_cnt  = (lock_q && (win_p0 == ptr_q)) ? cnt_q : '0;
    ptr_nxt  = ptr_q;
    cnt_nxt  = cnt_q;
    lock_nxt = lock_q;
    if (vld_p0) begin
      if (req_lock[win_p0] && (run_cnt < LOCK_LAST)) begin
        ptr_nxt  = win_p0;
        cnt_nxt  = run_cnt + CNT_W'(1);
        lock_nxt = 1'b1;
      end else begin
        ptr_nxt  = win_p0 + IDX_W'(1);
        cnt_nxt  = '0;
        lock_nxt = 1'b0;
      end
    end
  end

  // ---- Stage p1: registered write command and handshake ----
  logic [NUM_REQ-1:0] ack_p1;
  logic               vld_p1;
  logic [ADDR_W-1:0]  addr_p1;
  logic [DATA_W-1:0]  data_p1;
  logic               zero_p1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
      ack_p1  <= '0;
      vld_p1  <= 1'b0;
      zero_p1 <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      ack_p1  <= grant_p0;
      vld_p1  <= vld_p0 && !zero_p0;
      zero_p1 <= vld_p0 && zero_p0;
      // Index/data only move on an issued write; idle and register-0 grants
      // leave the last issued command visible on the port.
      if (vld_p0 && !zero_p0) begin
        addr_p1 <= addr_p0;
        data_p1 <= data_p0;
      end
      if (vld_p0) begin
        ptr_q  <= ptr_nxt;
        cnt_q  <= cnt_nxt;
        lock_q <= lock_nxt;
      end
    end
  end

  assign ack              = ack_p1;
  assign ctrl_writeEnable = vld_p1;
  assign ctrl_writeReg    = addr_p1;
  assign data_writeReg    = data_p1;
  assign zero_drop        = zero_p1;
  assign lock_active      = lock_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int LOCK_MAX = 4;

  logic                      clock = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic                      ctrl_writeEnable;
  logic [ADDR_W-1:0]         ctrl_writeReg;
  logic [DATA_W-1:0]         data_writeReg;
  logic                      zero_drop;
  logic                      lock_active;

  always #5 clock = ~clock;

  regfile_write_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data), .ack(ack),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .zero_drop(zero_drop),
    .lock_active(lock_active)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_all(input string name, input logic [3:0] e_ack, input logic e_en,
                           input logic [4:0] e_reg, input logic [31:0] e_data,
                           input logic e_zd, input logic e_lock);
    chk({name, ".ack"},  64'(ack), 64'(e_ack));
    chk({name, ".en"},   64'(ctrl_writeEnable), 64'(e_en));
    chk({name, ".reg"},  64'(ctrl_writeReg), 64'(e_reg));
    chk({name, ".data"}, 64'(data_writeReg), 64'(e_data));
    chk({name, ".zd"},   64'(zero_drop), 64'(e_zd));
    chk({name, ".lock"}, 64'(lock_active), 64'(e_lock));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic default_data();
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = 32'h100 + 32'(i);
  endtask

  // Table-driven vectors: inputs applied before an edge, outputs expected after it.
  typedef struct {
    logic [3:0]  rq;
    logic [3:0]  lk;
    logic [19:0] ad;
    logic [3:0]  e_ack;
    logic        e_en;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic        e_zd;
    logic        e_lock;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] rq, input logic [3:0] lk, input logic [19:0] ad,
                              input logic [3:0] e_ack, input logic e_en, input logic [4:0] e_reg,
                              input logic [31:0] e_data, input logic e_zd, input logic e_lock);
    vec_t v;
    v.rq = rq; v.lk = lk; v.ad = ad; v.e_ack = e_ack; v.e_en = e_en;
    v.e_reg = e_reg; v.e_data = e_data; v.e_zd = e_zd; v.e_lock = e_lock;
    return v;
  endfunction

  vec_t vecs [15];

  // Behavioural reference: round-robin with a burst tally per requester.
  int          m_ptr;
  int          m_run;
  bit          m_lock;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic [3:0]  e_ack;
  logic        e_en, e_zd;

  task automatic model_reset();
    m_ptr = 0; m_run = 0; m_lock = 0; m_reg = '0; m_data = '0;
  endtask

  task automatic model_step();
    int w;
    int run;
    logic [4:0] a;
    w = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w < 0 && req[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
    end
    e_ack = '0; e_en = 0; e_zd = 0;
    if (w >= 0) begin
      a = req_addr[w*ADDR_W +: ADDR_W];
      e_ack = 4'(1 << w);
      if (a == 0) e_zd = 1;
      else begin
        e_en = 1; m_reg = a; m_data = req_data[w*DATA_W +: DATA_W];
      end
      // Grants already taken in a row by this same locked requester.
      run = (m_lock && w == m_ptr) ? m_run : 0;
      if (req_lock[w] && run + 1 < LOCK_MAX) begin
        m_ptr = w; m_run = run + 1; m_lock = 1;
      end else begin
        m_ptr = (w + 1) % NUM_REQ; m_run = 0; m_lock = 0;
      end
    end
  endtask

  initial begin
    logic [19:0] a4321;
    logic [19:0] a4021;
    a4321 = {5'd4, 5'd3, 5'd2, 5'd1};
    a4021 = {5'd4, 5'd0, 5'd2, 5'd1};
    // rotation from pointer 0, then back round to pointer 0
    vecs[0]  = mk(4'b1111, 4'b0000, a4321, 4'b0001, 1, 5'd1, 32'h100, 0, 0);
    vecs[1]  = mk(4'b1111, 4'b0000, a4321, 4'b0010, 1, 5'd2, 32'h101, 0, 0);
    vecs[2]  = mk(4'b1111, 4'b0000, a4321, 4'b0100, 1, 5'd3, 32'h102, 0, 0);
    vecs[3]  = mk(4'b1111, 4'b0000, a4321, 4'b1000, 1, 5'd4, 32'h103, 0, 0);
    vecs[4]  = mk(4'b1111, 4'b0000, a4321, 4'b0001, 1, 5'd1, 32'h100, 0, 0);
    vecs[5]  = mk(4'b1111, 4'b0000, a4321, 4'b0010, 1, 5'd2, 32'h101, 0, 0);
    vecs[6]  = mk(4'b1111, 4'b0000, a4321, 4'b0100, 1, 5'd3, 32'h102, 0, 0);
    vecs[7]  = mk(4'b1111, 4'b0000, a4321, 4'b1000, 1, 5'd4, 32'h103, 0, 0);
    // burst of LOCK_MAX grants to requester 0, then requester 1
    vecs[8]  = mk(4'b0011, 4'b0001, a4321, 4'b0001, 1, 5'd1, 32'h100, 0, 1);
    vecs[9]  = mk(4'b0011, 4'b0001, a4321, 4'b0001, 1, 5'd1, 32'h100, 0, 1);
    vecs[10] = mk(4'b0011, 4'b0001, a4321, 4'b0001, 1, 5'd1, 32'h100, 0, 1);
    vecs[11] = mk(4'b0011, 4'b0001, a4321, 4'b0001, 1, 5'd1, 32'h100, 0, 0);
    vecs[12] = mk(4'b0011, 4'b0001, a4321, 4'b0010, 1, 5'd2, 32'h101, 0, 0);
    // register-0 write dropped, index/data hold, pointer moves to 3
    vecs[13] = mk(4'b0100, 4'b0000, a4021, 4'b0100, 0, 5'd2, 32'h101, 1, 0);
    vecs[14] = mk(4'b1001, 4'b0000, a4021, 4'b1000, 1, 5'd4, 32'h103, 0, 0);

    reset = 1'b1; req = '0; req_lock = '0; req_addr = '0; req_data = '0;
    #2 reset = 1'b0;
    @(posedge clock); #1;
    check_all("reset", 4'b0000, 0, 5'd0, 32'h0, 0, 0);
    reset = 1'b1;

    // single write, one-cycle latency
    req = 4'b0001; req_addr[4:0] = 5'd3; req_data[31:0] = 32'hDEADBEEF;
    tick();
    check_all("single", 4'b0001, 1, 5'd3, 32'hDEADBEEF, 0, 0);
    req = '0;
    tick();
    check_all("single_idle", 4'b0000, 0, 5'd3, 32'hDEADBEEF, 0, 0);

    pulse_reset();
    default_data();
    for (int i = 0; i < 15; i++) begin
      req = vecs[i].rq; req_lock = vecs[i].lk; req_addr = vecs[i].ad;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].e_ack, vecs[i].e_en, vecs[i].e_reg,
                vecs[i].e_data, vecs[i].e_zd, vecs[i].e_lock);
    end

    // reset in the middle of a burst
    req_addr = a4321; req = 4'b0011; req_lock = 4'b0001;
    tick();
    check_all("burst_a", 4'b0001, 1, 5'd1, 32'h100, 0, 1);
    tick();
    check_all("burst_b", 4'b0001, 1, 5'd1, 32'h100, 0, 1);
    reset = 1'b0;
    #1;
    check_all("async_rst", 4'b0000, 0, 5'd0, 32'h0, 0, 0);
    #1 reset = 1'b1;
    for (int k = 0; k < LOCK_MAX; k++) begin
      tick();
      check_all($sformatf("post_rst%0d", k), 4'b0001, 1, 5'd1, 32'h100, 0, k < LOCK_MAX - 1);
    end
    tick();
    check_all("post_rst_next", 4'b0010, 1, 5'd2, 32'h101, 0, 0);

    // request withdrawn before an edge: nothing issued, pointer stays at 2
    req = '0; req_lock = '0;
    #1 req = 4'b0010;
    #2 req = '0;
    tick();
    check_all("withdraw", 4'b0000, 0, 5'd2, 32'h101, 0, 0);
    req = 4'b1111;
    tick();
    check_all("withdraw_ptr", 4'b0100, 1, 5'd3, 32'h102, 0, 0);

    // randomized traffic against the reference model
    req = '0; req_lock = '0;
    pulse_reset();
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      req = 4'($urandom);
      if ($urandom_range(0, 7) == 0) req = '0;
      req_lock = 4'($urandom) & 4'($urandom);
      for (int i = 0; i < NUM_REQ; i++) begin
        req_addr[i*ADDR_W +: ADDR_W] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        req_data[i*DATA_W +: DATA_W] = $urandom;
      end
      model_step();
      tick();
      check_all($sformatf("rnd%0d", c), e_ack, e_en, m_reg, m_data, e_zd, m_lock);
      chk($sformatf("rnd%0d.onehot", c), 64'($countones(ack) <= 1), 64'(1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port among NUM_REQ requesters using round-robin arbitration.
- Optional short bursts let one requester hold the port for several writes in a row.
- Issues one registered write command per cycle (enable, register index, data) to the regfile write port, which is built from the team's latch/flop storage cells.
- Writes to register 0 are acknowledged but never issued, because register 0 is hard-wired to zero.

Parameters:
- NUM_REQ, 4, number of requesters; power of two, 2 to 8.
- ADDR_W, 5, register index width (32 registers).
- DATA_W, 32, write data width.
- LOCK_MAX, 4, maximum consecutive grants to one locked requester.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- req  input  NUM_REQ  per-requester write request, level-sensitive.
- req_lock  input  NUM_REQ  requester asks to keep priority for its next write.
- req_addr  input  NUM_REQ*ADDR_W  packed register indices; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  packed write data, same packing.
- ack  output  NUM_REQ  one-hot, one-cycle pulse: the request was consumed.
- ctrl_writeEnable  output  1  regfile write enable, registered.
- ctrl_writeReg  output  ADDR_W  regfile write index, registered.
- data_writeReg  output  DATA_W  regfile write data, registered.
- zero_drop  output  1  one-cycle pulse: a granted write targeted register 0 and was discarded.
- lock_active  output  1  a burst is in progress.

Behaviour:
- Reset (reset=0, asynchronous):
  - ack=0, ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, zero_drop=0, lock_active=0.
  - Priority pointer=0, burst counter=0.
- Arbitration is combinational on the sampled req.
  - Winner = first asserted req scanning from the pointer upward, wrapping at NUM_REQ-1 to 0.
  - On the next rising edge, the winner's address and data are registered onto the write outputs and ack[winner] pulses high for that one cycle.
  - Latency is exactly 1 cycle from a req seen at an edge to the write/ack. Throughput is one write per cycle.
- Handshake:
  - A requester holds req, addr and data stable until ack.
  - If req is still high in the cycle ack is high, that is a new, distinct request, arbitrated at the next edge.
  - Deasserting req before ack withdraws the request; nothing is issued.
- Pointer update on a grant:
  - Default: pointer = winner+1, mod NUM_REQ.
  - Lock: if req_lock[winner]=1 and burst count < LOCK_MAX-1, the pointer stays at winner, the burst count increments and lock_active=1.
  - When the count reaches LOCK_MAX-1, or the winner drops lock, the pointer advances to winner+1, the count clears and lock_active=0.
  - A locked requester that drops req loses the lock; the pointer advances past it on the next arbitration.
- Idle: no req → ctrl_writeEnable=0, ack=0, zero_drop=0. Pointer and burst count are unchanged; the data/index outputs hold their last value.
- Register 0: a granted write with address 0 gives ack=1, zero_drop=1, ctrl_writeEnable=0. The pointer and lock update as for a normal grant.
- Simultaneous requests: exactly one ack per cycle, never more. Losers keep waiting; fairness bound is NUM_REQ*LOCK_MAX cycles.
- Reset mid-burst: the in-flight output write is dropped (enable forced to 0 asynchronously); the lock clears and the pointer returns to 0.
- Release of reset is synchronised by the team's standard reset synchroniser outside this block; this block assumes a clean deassertion.

Test Plan:
1. Reset, then req=0001, addr0=3, data0=0xDEADBEEF → next cycle: ack=0001, ctrl_writeEnable=1, ctrl_writeReg=3, data_writeReg=0xDEADBEEF; following cycle enable=0.
2. req=1111 held constant, no lock, addresses 1..4 → acks rotate 0001,0010,0100,1000,0001 on consecutive cycles; enable stays high every cycle.
3. req=0011, req_lock=0001, LOCK_MAX=4 → requester 0 acked 4 consecutive cycles with lock_active=1 on the first 3; then requester 1 is acked; lock_active=0.
4. req=0100 with addr2=0 → ack=0100, zero_drop=1, ctrl_writeEnable=0; the next grant to requester 3 proves the pointer advanced.
5. Burst in progress (2 grants in), reset pulsed low mid-cycle → ctrl_writeEnable and ack drop to 0 immediately. After release with req=0011, requester 0 wins first, proving pointer=0 and the lock cleared.
6. req=0010 raised then dropped before an edge → no ack, no write, pointer unchanged.
